// File: rtl/udp_rx_buffer.sv
// udp_rx_buffer: receive-side payload buffer. Bytes land in a circular RAM, only cleanly
// terminated frames are committed, and committed frames are replayed over valid/ready.
module udp_rx_buffer #(
    parameter int DEPTH_LOG2 = 11,
    parameter int LEN_LOG2   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rec_en,
    input  logic [7:0]            rec_data,
    input  logic                  rec_pkt_done,
    input  logic                  rec_err,
    input  logic [15:0]           rec_byte_num,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [7:0]            m_data,
    output logic                  m_last,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           drop_cnt,
    output logic [DEPTH_LOG2:0]   free_bytes
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam int LW = LEN_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0] ONE_P  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LFULL  = {1'b1, {LEN_LOG2{1'b0}}};
    localparam logic [LW-1:0] ONE_L  = {{(LW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_BAD} wstate_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [7:0]     mem [2**DEPTH_LOG2];
    logic [PW-1:0]  len_mem [2**LEN_LOG2];

    wstate_t        state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, commit_ptr_q, rd_ptr_q, cur_len_q, rd_idx_q;
    logic [LW-1:0]  len_wr_q, len_fetch_q, len_rd_q;
    logic [15:0]    frame_cnt_q, drop_cnt_q;
    logic [PW-1:0]  free_q;

    logic           ram_vld_p1_q, ram_last_p1_q;
    logic [7:0]     ram_data_p1_q;
    logic [1:0]     skid_cnt_q;
    logic [7:0]     e0_data_q, e1_data_q;
    logic           e0_last_q, e1_last_q;

    logic [PW-1:0]  used, len_inc, wr_ptr_nx, fetch_len;
    logic [LW-1:0]  len_cnt;
    logic           ram_full, len_full, frame_active, len_ok;
    logic           wr_ok, commit, drop;
    logic           frames_pending, room, fetch, fetch_last, push, pop;

    assign used         = wr_ptr_q - rd_ptr_q;
    assign ram_full     = (used == DEPTH);
    assign len_cnt      = len_wr_q - len_rd_q;
    assign len_full     = (len_cnt == LFULL);
    assign len_inc      = cur_len_q + (wr_ok ? ONE_P : '0);
    assign wr_ptr_nx    = wr_ptr_q + (wr_ok ? ONE_P : '0);
    assign frame_active = (state_q == S_RECV) || rec_en;
    assign len_ok       = !(rec_en && ram_full) && (32'(len_inc) == 32'(rec_byte_num))
                          && (len_inc != '0) && !len_full;

    // write FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // write FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (rec_err || rec_pkt_done) state_d = S_IDLE;
                else if (rec_en)             state_d = ram_full ? S_BAD : S_RECV;
            end
            S_RECV: begin
                if (rec_err || rec_pkt_done) state_d = S_IDLE;
                else if (rec_en && ram_full) state_d = S_BAD;
            end
            S_BAD: begin
                if (rec_err || rec_pkt_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // write FSM: outputs
    always_comb begin
        wr_ok  = 1'b0;
        commit = 1'b0;
        drop   = 1'b0;
        unique case (state_q)
            S_IDLE, S_RECV: begin
                wr_ok = rec_en && !ram_full && !rec_err;
                if (rec_err) begin
                    drop = 1'b1;
                end else if (rec_pkt_done && frame_active) begin
                    commit = len_ok;
                    drop   = !len_ok;
                end
            end
            S_BAD:   drop = rec_pkt_done || rec_err;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            cur_len_q    <= '0;
            len_wr_q     <= '0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            free_q       <= DEPTH;
        end else begin
            free_q <= DEPTH - used;
            if (drop) begin
                wr_ptr_q   <= commit_ptr_q;
                cur_len_q  <= '0;
                drop_cnt_q <= sat_inc16(drop_cnt_q);
            end else begin
                wr_ptr_q <= wr_ptr_nx;
                if (commit) begin
                    commit_ptr_q <= wr_ptr_nx;
                    cur_len_q    <= '0;
                    len_wr_q     <= len_wr_q + ONE_L;
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                end else if (wr_ok) begin
                    cur_len_q <= len_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)  mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= rec_data;
        if (commit) len_mem[len_wr_q[LEN_LOG2-1:0]] <= len_inc;
    end

    // fetch side runs ahead of the sink, so it keeps its own index into the length FIFO
    assign frames_pending = (len_wr_q != len_fetch_q);
    assign fetch_len      = len_mem[len_fetch_q[LEN_LOG2-1:0]];
    assign fetch_last     = (rd_idx_q == fetch_len - ONE_P);
    assign pop            = m_valid && m_ready;
    assign push           = ram_vld_p1_q;
    assign room           = (3'(skid_cnt_q) + 3'(ram_vld_p1_q)) < (3'd2 + 3'(pop));
    assign fetch          = frames_pending && (rd_ptr_q != commit_ptr_q) && room;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            rd_idx_q     <= '0;
            len_fetch_q  <= '0;
            len_rd_q     <= '0;
            ram_vld_p1_q <= 1'b0;
        end else begin
            ram_vld_p1_q <= fetch;
            if (fetch) begin
                rd_ptr_q <= rd_ptr_q + ONE_P;
                if (fetch_last) begin
                    rd_idx_q    <= '0;
                    len_fetch_q <= len_fetch_q + ONE_L;
                end else begin
                    rd_idx_q <= rd_idx_q + ONE_P;
                end
            end
            if (pop && m_last) len_rd_q <= len_rd_q + ONE_L;
        end
    end

    // stage p1: registered RAM read
    always_ff @(posedge clk) begin
        if (fetch) begin
            ram_data_p1_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
            ram_last_p1_q <= fetch_last;
        end
    end

    // stage p2: two-entry skid, e0 is the presented head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_cnt_q <= '0;
            e0_data_q  <= '0;
            e0_last_q  <= 1'b0;
            e1_data_q  <= '0;
            e1_last_q  <= 1'b0;
        end else begin
            skid_cnt_q <= skid_cnt_q + (push ? 2'd1 : 2'd0) - (pop ? 2'd1 : 2'd0);
            if (pop) begin
                if (skid_cnt_q == 2'd2) begin
                    e0_data_q <= e1_data_q;
                    e0_last_q <= e1_last_q;
                    if (push) begin
                        e1_data_q <= ram_data_p1_q;
                        e1_last_q <= ram_last_p1_q;
                    end
                end else if (push) begin
                    e0_data_q <= ram_data_p1_q;
                    e0_last_q <= ram_last_p1_q;
                end
            end else if (push) begin
                if (skid_cnt_q == 2'd0) begin
                    e0_data_q <= ram_data_p1_q;
                    e0_last_q <= ram_last_p1_q;
                end else begin
                    e1_data_q <= ram_data_p1_q;
                    e1_last_q <= ram_last_p1_q;
                end
            end
        end
    end

    assign m_valid    = (skid_cnt_q != 2'd0);
    assign m_data     = e0_data_q;
    assign m_last     = e0_last_q && m_valid;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign free_bytes = free_q;

endmodule

// File: tb/tb_udp_rx_buffer.sv
// Directed testbench for udp_rx_buffer: a default-size instance plus a 16-byte instance
// for the overflow case.
module tb_udp_rx_buffer;
    logic        clk = 1'b0;
    logic        rst_n;

    logic        rec_en, rec_pkt_done, rec_err, m_ready;
    logic [7:0]  rec_data;
    logic [15:0] rec_byte_num;
    logic        m_valid, m_last;
    logic [7:0]  m_data;
    logic [15:0] frame_cnt, drop_cnt;
    logic [11:0] free_bytes;

    logic        s_rec_en, s_rec_pkt_done, s_rec_err, s_m_ready;
    logic [7:0]  s_rec_data;
    logic [15:0] s_rec_byte_num;
    logic        s_m_valid, s_m_last;
    logic [7:0]  s_m_data;
    logic [15:0] s_frame_cnt, s_drop_cnt;
    logic [4:0]  s_free_bytes;

    int checks = 0;
    int errors = 0;
    logic [8:0] expq[$];

    always #5 clk = ~clk;

    udp_rx_buffer dut (
        .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .rec_data(rec_data),
        .rec_pkt_done(rec_pkt_done), .rec_err(rec_err), .rec_byte_num(rec_byte_num),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .free_bytes(free_bytes)
    );

    udp_rx_buffer #(.DEPTH_LOG2(4), .LEN_LOG2(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .rec_en(s_rec_en), .rec_data(s_rec_data),
        .rec_pkt_done(s_rec_pkt_done), .rec_err(s_rec_err), .rec_byte_num(s_rec_byte_num),
        .m_valid(s_m_valid), .m_ready(s_m_ready), .m_data(s_m_data), .m_last(s_m_last),
        .frame_cnt(s_frame_cnt), .drop_cnt(s_drop_cnt), .free_bytes(s_free_bytes)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic en, input logic [7:0] d, input logic done,
                         input logic err, input logic [15:0] num);
        if (sel) begin
            s_rec_en = en; s_rec_data = d; s_rec_pkt_done = done; s_rec_err = err; s_rec_byte_num = num;
        end else begin
            rec_en = en; rec_data = d; rec_pkt_done = done; rec_err = err; rec_byte_num = num;
        end
    endtask

    task automatic send_bytes(input bit sel, input int n, input logic [7:0] base,
                              input int declared, input bit done_with_last);
        logic [7:0] d;
        d = base;
        for (int i = 0; i < n; i++) begin
            drive(sel, 1'b1, d, done_with_last && (i == n - 1), 1'b0, 16'(declared));
            tick();
            d = d + 8'd1;
        end
        drive(sel, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic send_frame(input bit sel, input int n, input logic [7:0] base,
                              input int declared, input bit done_with_last);
        send_bytes(sel, n, base, declared, done_with_last);
        if (!done_with_last) begin
            drive(sel, 1'b0, 8'h00, 1'b1, 1'b0, 16'(declared));
            tick();
            drive(sel, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
        end
    endtask

    task automatic expect_frame(input int n, input logic [7:0] base);
        logic [7:0] d;
        d = base;
        for (int i = 0; i < n; i++) begin
            expq.push_back({(i == n - 1), d});
            d = d + 8'd1;
        end
    endtask

    task automatic collect(input bit sel, input bit toggle, input int budget);
        int   cyc;
        bit   rdy;
        logic v, lst;
        logic [7:0] dat;
        cyc = 0;
        rdy = 1'b1;
        while (expq.size() != 0 && cyc < budget) begin
            if (sel) s_m_ready = rdy; else m_ready = rdy;
            v   = sel ? s_m_valid : m_valid;
            dat = sel ? s_m_data  : m_data;
            lst = sel ? s_m_last  : m_last;
            if (v) begin
                chk("beat data", 32'(dat), 32'(expq[0][7:0]));
                chk("beat last", 32'(lst), 32'(expq[0][8]));
                if (rdy) void'(expq.pop_front());
            end
            if (toggle) rdy = !rdy;
            tick();
            cyc++;
        end
        chk("beats left undelivered", 32'(expq.size()), 0);
        expq.delete();
        tick();
        v = sel ? s_m_valid : m_valid;
        chk("no extra beat", 32'(v), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        rst_n = 1'b0;
        m_ready = 1'b0;
        s_m_ready = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
        tick(); tick();
        chk("reset m_valid", 32'(m_valid), 0);
        chk("reset m_last", 32'(m_last), 0);
        chk("reset m_data", 32'(m_data), 0);
        chk("reset frame_cnt", 32'(frame_cnt), 0);
        chk("reset drop_cnt", 32'(drop_cnt), 0);
        chk("reset free_bytes", 32'(free_bytes), 2048);
        chk("reset small free_bytes", 32'(s_free_bytes), 16);
        rst_n = 1'b1;
        tick();

        // T1: 16-byte frame, first valid two cycles after the commit edge
        m_ready = 1'b1;
        send_frame(1'b0, 16, 8'h00, 16, 1'b0);
        chk("t1 valid at commit+0", 32'(m_valid), 0);
        tick();
        chk("t1 valid at commit+1", 32'(m_valid), 0);
        tick();
        chk("t1 valid at commit+2", 32'(m_valid), 1);
        expect_frame(16, 8'h00);
        collect(1'b0, 1'b0, 40);
        chk("t1 frame_cnt", 32'(frame_cnt), 1);
        chk("t1 free_bytes", 32'(free_bytes), 2048);

        // T2: length mismatch is dropped
        send_frame(1'b0, 10, 8'h60, 12, 1'b0);
        chk("t2 drop_cnt", 32'(drop_cnt), 1);
        chk("t2 free before rollback", 32'(free_bytes), 2038);
        tick();
        chk("t2 free after rollback", 32'(free_bytes), 2048);
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_valid) vcount++;
            tick();
        end
        chk("t2 no output beats", 32'(vcount), 0);
        chk("t2 frame_cnt", 32'(frame_cnt), 1);

        // T3: 16-byte RAM overflow, then an 8-byte frame intact
        s_m_ready = 1'b0;
        send_frame(1'b1, 20, 8'h00, 20, 1'b0);
        chk("t3 drop_cnt", 32'(s_drop_cnt), 1);
        chk("t3 frame_cnt", 32'(s_frame_cnt), 0);
        chk("t3 free while full", 32'(s_free_bytes), 0);
        tick();
        chk("t3 free after rollback", 32'(s_free_bytes), 16);
        chk("t3 no output", 32'(s_m_valid), 0);
        send_frame(1'b1, 8, 8'h80, 8, 1'b0);
        expect_frame(8, 8'h80);
        collect(1'b1, 1'b0, 40);
        chk("t3 frame_cnt after", 32'(s_frame_cnt), 1);
        chk("t3 drop_cnt after", 32'(s_drop_cnt), 1);

        // T4: rec_err mid-frame, then a clean 4-byte frame
        send_bytes(1'b0, 5, 8'h01, 0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
        chk("t4 drop_cnt", 32'(drop_cnt), 2);
        send_frame(1'b0, 4, 8'hA0, 4, 1'b0);
        expect_frame(4, 8'hA0);
        collect(1'b0, 1'b0, 30);
        chk("t4 frame_cnt", 32'(frame_cnt), 2);

        // T5: three back-to-back 3-byte frames, done on the last byte, sink toggling
        m_ready = 1'b0;
        send_frame(1'b0, 3, 8'h10, 3, 1'b1);
        send_frame(1'b0, 3, 8'h20, 3, 1'b1);
        send_frame(1'b0, 3, 8'h30, 3, 1'b1);
        tick(); tick();
        chk("t5 frame_cnt", 32'(frame_cnt), 5);
        expect_frame(3, 8'h10);
        expect_frame(3, 8'h20);
        expect_frame(3, 8'h30);
        collect(1'b0, 1'b1, 60);
        chk("t5 drop_cnt", 32'(drop_cnt), 2);

        // T6: reset during output
        m_ready = 1'b1;
        send_frame(1'b0, 16, 8'h40, 16, 1'b0);
        tick(); tick(); tick();
        chk("t6 output active", 32'(m_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6 reset m_valid", 32'(m_valid), 0);
        chk("t6 reset m_last", 32'(m_last), 0);
        chk("t6 reset frame_cnt", 32'(frame_cnt), 0);
        chk("t6 reset drop_cnt", 32'(drop_cnt), 0);
        chk("t6 reset free_bytes", 32'(free_bytes), 2048);
        tick(); tick();
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid) vcount++;
            tick();
        end
        chk("t6 no residual beats", 32'(vcount), 0);
        send_frame(1'b0, 2, 8'h55, 2, 1'b0);
        expect_frame(2, 8'h55);
        collect(1'b0, 1'b0, 20);
        chk("t6 frame_cnt after", 32'(frame_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
